// File: rtl/xc20xx_clb_cfg_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module : xc20xx_clb_cfg_loader_pkg
// Brief  : Shared types, error codes, CFG_WORD field map and length helper.
// Rev    : 1.0
// ============================================================================
package xc20xx_clb_cfg_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LENGTH = 3'd1,
    ST_FSTART = 3'd2,
    ST_FDATA  = 3'd3,
    ST_FSTOP  = 3'd4,
    ST_WRITE  = 3'd5,
    ST_FIN    = 3'd6,
    ST_FAIL   = 3'd7
  } state_t;

  localparam logic [1:0] ERR_NONE  = 2'd0;
  localparam logic [1:0] ERR_START = 2'd1;
  localparam logic [1:0] ERR_STOP  = 2'd2;
  localparam logic [1:0] ERR_LEN   = 2'd3;

  localparam logic [3:0] SYNC_PATTERN = 4'b0010;
  localparam logic [2:0] HIST_RESET   = 3'b111;
  localparam int         LEN_BITS     = 24;
  localparam int         STOP_BITS    = 3;

  // CFG_WORD field map for the 38-bit frame (LSB position, width)
  localparam int F_INIT_LSB  = 30;  localparam int F_INIT_W  = 8;
  localparam int G_INIT_LSB  = 22;  localparam int G_INIT_W  = 8;
  localparam int F_IN0_LSB   = 21;  localparam int F_IN0_W   = 1;
  localparam int F_IN1_LSB   = 20;  localparam int F_IN1_W   = 1;
  localparam int F_IN2_LSB   = 18;  localparam int F_IN2_W   = 2;
  localparam int G_IN0_LSB   = 17;  localparam int G_IN0_W   = 1;
  localparam int G_IN1_LSB   = 16;  localparam int G_IN1_W   = 1;
  localparam int G_IN2_LSB   = 14;  localparam int G_IN2_W   = 2;
  localparam int MUX_FG_LSB  = 13;  localparam int MUX_FG_W  = 1;
  localparam int X_OUT_LSB   = 11;  localparam int X_OUT_W   = 2;
  localparam int Y_OUT_LSB   = 9;   localparam int Y_OUT_W   = 2;
  localparam int S_IN_LSB    = 7;   localparam int S_IN_W    = 2;
  localparam int CLK_IN_LSB  = 5;   localparam int CLK_IN_W  = 2;
  localparam int CLK_POL_LSB = 3;   localparam int CLK_POL_W = 2;
  localparam int MODE_LSB    = 2;   localparam int MODE_W    = 1;
  localparam int R_IN_LSB    = 0;   localparam int R_IN_W    = 2;

  // Total stream length: 28 header bits plus start + data + 3 stop per frame
  function automatic logic [LEN_BITS-1:0] expected_len(input int num_clb, input int cfg_bits);
    return LEN_BITS'(28 + num_clb * (cfg_bits + 1 + STOP_BITS));
  endfunction

  function automatic int addr_w(input int num_clb);
    return (num_clb > 1) ? $clog2(num_clb) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/xc20xx_clb_cfg_loader_if.sv
`default_nettype none
// ============================================================================
// Module : xc20xx_clb_cfg_loader_if
// Brief  : Serial bitstream in / CLB config write port bundle.
// Rev    : 1.0
// ============================================================================
interface xc20xx_clb_cfg_loader_if #(
  parameter int NUM_CLB  = 64,
  parameter int CFG_BITS = 38
);
  localparam int AW = xc20xx_clb_cfg_loader_pkg::addr_w(NUM_CLB);

  logic                DIN;
  logic                DVALID;
  logic [CFG_BITS-1:0] CFG_WORD;
  logic [AW-1:0]       CFG_ADDR;
  logic                CFG_WE;
  logic                BUSY;
  logic                DONE;
  logic                ERR;
  logic [1:0]          ERR_CODE;

  modport master (
    output DIN, DVALID,
    input  CFG_WORD, CFG_ADDR, CFG_WE, BUSY, DONE, ERR, ERR_CODE
  );

  modport slave (
    input  DIN, DVALID,
    output CFG_WORD, CFG_ADDR, CFG_WE, BUSY, DONE, ERR, ERR_CODE
  );

endinterface
`default_nettype wire

// File: rtl/xc20xx_cfg_frame_shift.sv
`default_nettype none
// ============================================================================
// Module : xc20xx_cfg_frame_shift
// Brief  : MSB-first frame deserializer with bit counter and last-bit flag.
// Rev    : 1.0
// ============================================================================
module xc20xx_cfg_frame_shift #(
  parameter int CFG_BITS = 38
) (
  input  wire logic                clk,
  input  wire logic                rst,
  input  wire logic                shift_en,
  input  wire logic                din,
  output logic      [CFG_BITS-1:0] frame,
  output logic                     last
);
  localparam int CW = $clog2(CFG_BITS + 1);

  logic [CW-1:0] cnt;

  assign last = (cnt == CW'(CFG_BITS - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      frame <= '0;
      cnt   <= '0;
    end else if (shift_en) begin
      frame <= {frame[CFG_BITS-2:0], din};
      cnt   <= last ? '0 : cnt + CW'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/xc20xx_clb_cfg_loader.sv
`default_nettype none
// ============================================================================
// Module : xc20xx_clb_cfg_loader
// Brief  : Serial bitstream parser that writes CLB configuration frames.
// Rev    : 1.0
// ============================================================================
module xc20xx_clb_cfg_loader
  import xc20xx_clb_cfg_loader_pkg::*;
#(
  parameter int NUM_CLB  = 64,
  parameter int CFG_BITS = 38
) (
  input  wire logic K,
  input  wire logic R,
  xc20xx_clb_cfg_loader_if.slave bus
);
  localparam int                  AW      = addr_w(NUM_CLB);
  localparam logic [LEN_BITS-1:0] EXP_LEN = expected_len(NUM_CLB, CFG_BITS);

  state_t              state, state_n;
  logic [1:0]          err_n, err_code;
  logic [2:0]          hist;
  logic [3:0]          hist_next;
  logic [LEN_BITS-2:0] len_sh;
  logic [4:0]          len_cnt;
  logic [1:0]          stop_cnt;
  logic [AW-1:0]       idx, addr;
  logic [CFG_BITS-1:0] word, frame;
  logic                we, frame_last, shift_en;

  // Only three history bits are stored; with DIN they form the 4-bit window
  assign hist_next = {hist, bus.DIN};
  assign shift_en  = (state == ST_FDATA) && bus.DVALID;

  xc20xx_cfg_frame_shift #(.CFG_BITS(CFG_BITS)) u_frame (
    .clk      (K),
    .rst      (R),
    .shift_en (shift_en),
    .din      (bus.DIN),
    .frame    (frame),
    .last     (frame_last)
  );

  always_comb begin
    state_n = state;
    err_n   = ERR_NONE;
    case (state)
      ST_IDLE:   if (bus.DVALID && hist_next == SYNC_PATTERN) state_n = ST_LENGTH;
      ST_LENGTH: if (bus.DVALID && len_cnt == 5'(LEN_BITS - 1)) begin
        if ({len_sh, bus.DIN} != EXP_LEN) begin
          state_n = ST_FAIL;
          err_n   = ERR_LEN;
        end else begin
          state_n = ST_FSTART;
        end
      end
      ST_FSTART: if (bus.DVALID) begin
        if (bus.DIN) begin
          state_n = ST_FAIL;
          err_n   = ERR_START;
        end else begin
          state_n = ST_FDATA;
        end
      end
      ST_FDATA:  if (bus.DVALID && frame_last) state_n = ST_FSTOP;
      ST_FSTOP:  if (bus.DVALID) begin
        if (!bus.DIN) begin
          state_n = ST_FAIL;
          err_n   = ERR_STOP;
        end else if (stop_cnt == 2'(STOP_BITS - 1)) begin
          state_n = ST_WRITE;
        end
      end
      ST_WRITE:  state_n = (idx == AW'(NUM_CLB - 1)) ? ST_FIN : ST_FSTART;
      default:   state_n = state;
    endcase
  end

  always_ff @(posedge K) begin
    if (R) begin
      state    <= ST_IDLE;
      hist     <= HIST_RESET;
      len_sh   <= '0;
      len_cnt  <= '0;
      stop_cnt <= '0;
      idx      <= '0;
      word     <= '0;
      addr     <= '0;
      we       <= 1'b0;
      err_code <= ERR_NONE;
    end else begin
      state <= state_n;
      we    <= (state_n == ST_WRITE);
      if (state != ST_FAIL && state_n == ST_FAIL) err_code <= err_n;
      if (state == ST_IDLE && bus.DVALID) hist <= hist_next[2:0];
      if (state != ST_LENGTH) begin
        len_cnt <= '0;
      end else if (bus.DVALID) begin
        len_sh  <= {len_sh[LEN_BITS-3:0], bus.DIN};
        len_cnt <= len_cnt + 5'd1;
      end
      if (state != ST_FSTOP)   stop_cnt <= '0;
      else if (bus.DVALID)     stop_cnt <= stop_cnt + 2'd1;
      // Output word/address are latched on entry to WRITE and held afterwards
      if (state_n == ST_WRITE) begin
        word <= frame;
        addr <= idx;
      end
      if (state == ST_WRITE && state_n == ST_FSTART) idx <= idx + AW'(1);
    end
  end

  assign bus.CFG_WORD = word;
  assign bus.CFG_ADDR = addr;
  assign bus.CFG_WE   = we;
  assign bus.BUSY     = (state == ST_LENGTH) || (state == ST_FSTART) ||
                        (state == ST_FDATA)  || (state == ST_FSTOP);
  assign bus.DONE     = (state == ST_FIN);
  assign bus.ERR      = (state == ST_FAIL);
  assign bus.ERR_CODE = err_code;

endmodule
`default_nettype wire

// File: tb/tb_xc20xx_clb_cfg_loader.sv
`default_nettype none
// ============================================================================
// Module : tb_xc20xx_clb_cfg_loader
// Brief  : Directed self-checking bench for the CLB configuration loader.
// Rev    : 1.0
// ============================================================================
module tb_xc20xx_clb_cfg_loader;
  localparam int NC = 4;
  localparam int CB = 38;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  xc20xx_clb_cfg_loader_if #(.NUM_CLB(NC), .CFG_BITS(CB)) bus ();

  xc20xx_clb_cfg_loader #(.NUM_CLB(NC), .CFG_BITS(CB)) dut (
    .K   (clk),
    .R   (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;
  bit gaps  = 1'b0;

  logic [CB-1:0] words   [NC];
  logic [CB-1:0] we_word [64];
  int            we_addr [64];
  int            we_n = 0;

  always @(negedge clk) begin
    if (bus.CFG_WE === 1'b1) begin
      if (we_n < 64) begin
        we_word[we_n] = bus.CFG_WORD;
        we_addr[we_n] = int'(bus.CFG_ADDR);
      end
      we_n++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    if (gaps) begin
      repeat ($urandom_range(0, 5)) begin
        bus.DVALID = 1'b0;
        tick();
      end
    end
    bus.DIN    = b;
    bus.DVALID = 1'b1;
    tick();
    bus.DVALID = 1'b0;
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    bus.DVALID = 1'b0;
    bus.DIN    = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Abort points: bad_start/bad_stop/cut_frame index a frame, -1 disables
  task automatic send_stream(input int len, input int bad_start, input int bad_stop,
                             input int cut_frame);
    logic [7:0]    pre;
    logic [23:0]   lv;
    logic [CB-1:0] w;
    pre = 8'b1111_0010;
    lv  = 24'(len);
    for (int i = 7; i >= 0; i--) send_bit(pre[i]);
    for (int i = 23; i >= 0; i--) send_bit(lv[i]);
    for (int f = 0; f < NC; f++) begin
      w = words[f];
      if (f > 0) begin
        // WRITE cycle: next start bit shown once, ignored, then held
        bus.DIN    = (f == bad_start);
        bus.DVALID = 1'b1;
        tick();
        bus.DVALID = 1'b0;
      end
      send_bit(f == bad_start);
      if (f == bad_start) return;
      for (int i = CB - 1; i >= 0; i--) begin
        if (f == cut_frame && i == CB - 11) return;
        send_bit(w[i]);
      end
      for (int s = 0; s < 3; s++) begin
        send_bit(!(f == bad_stop && s == 1));
        if (f == bad_stop && s == 1) return;
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (bus.CFG_WORD !== '0)   begin bad++; $display("FAIL reset_word: got %h want 0", bus.CFG_WORD); end
    total++; if (bus.CFG_ADDR !== '0)   begin bad++; $display("FAIL reset_addr: got %0d want 0", bus.CFG_ADDR); end
    total++; if (bus.CFG_WE !== 1'b0)   begin bad++; $display("FAIL reset_we: got %b want 0", bus.CFG_WE); end
    total++; if (bus.BUSY !== 1'b0)     begin bad++; $display("FAIL reset_busy: got %b want 0", bus.BUSY); end
    total++; if (bus.DONE !== 1'b0)     begin bad++; $display("FAIL reset_done: got %b want 0", bus.DONE); end
    total++; if (bus.ERR !== 1'b0)      begin bad++; $display("FAIL reset_err: got %b want 0", bus.ERR); end
    total++; if (bus.ERR_CODE !== 2'd0) begin bad++; $display("FAIL reset_code: got %0d want 0", bus.ERR_CODE); end
  endtask

  task automatic test_nominal(input bit use_gaps);
    int base;
    do_reset();
    base = we_n;
    gaps = use_gaps;
    send_stream(196, -1, -1, -1);
    gaps = 1'b0;
    repeat (4) tick();
    total++; if (we_n - base !== NC) begin bad++; $display("FAIL nominal_pulses(gaps=%0d): got %0d want %0d", use_gaps, we_n - base, NC); end
    for (int k = 0; k < NC; k++) begin
      total++; if (we_addr[base+k] !== k) begin bad++; $display("FAIL nominal_addr%0d: got %0d want %0d", k, we_addr[base+k], k); end
      total++; if (we_word[base+k] !== words[k]) begin bad++; $display("FAIL nominal_word%0d: got %h want %h", k, we_word[base+k], words[k]); end
    end
    total++; if (bus.DONE !== 1'b1) begin bad++; $display("FAIL nominal_done: got %b want 1", bus.DONE); end
    total++; if (bus.ERR !== 1'b0)  begin bad++; $display("FAIL nominal_err: got %b want 0", bus.ERR); end
    total++; if (bus.BUSY !== 1'b0) begin bad++; $display("FAIL nominal_busy: got %b want 0", bus.BUSY); end
    total++; if (bus.CFG_WORD !== words[NC-1]) begin bad++; $display("FAIL nominal_hold_word: got %h want %h", bus.CFG_WORD, words[NC-1]); end
    total++; if (bus.CFG_ADDR !== 2'(NC-1)) begin bad++; $display("FAIL nominal_hold_addr: got %0d want %0d", bus.CFG_ADDR, NC-1); end
  endtask

  task automatic test_bad_length();
    int base;
    do_reset();
    base = we_n;
    send_stream(197, -1, -1, -1);
    repeat (4) tick();
    total++; if (bus.ERR !== 1'b1)      begin bad++; $display("FAIL len_err: got %b want 1", bus.ERR); end
    total++; if (bus.ERR_CODE !== 2'd3) begin bad++; $display("FAIL len_code: got %0d want 3", bus.ERR_CODE); end
    total++; if (we_n != base)          begin bad++; $display("FAIL len_pulses: got %0d want 0", we_n - base); end
    total++; if (bus.DONE !== 1'b0)     begin bad++; $display("FAIL len_done: got %b want 0", bus.DONE); end
  endtask

  task automatic test_bad_start();
    int base;
    do_reset();
    base = we_n;
    send_stream(196, 2, -1, -1);
    repeat (4) tick();
    total++; if (we_n - base !== 2) begin bad++; $display("FAIL start_pulses: got %0d want 2", we_n - base); end
    for (int k = 0; k < 2; k++) begin
      total++; if (we_addr[base+k] !== k) begin bad++; $display("FAIL start_addr%0d: got %0d want %0d", k, we_addr[base+k], k); end
      total++; if (we_word[base+k] !== words[k]) begin bad++; $display("FAIL start_word%0d: got %h want %h", k, we_word[base+k], words[k]); end
    end
    total++; if (bus.ERR_CODE !== 2'd1) begin bad++; $display("FAIL start_code: got %0d want 1", bus.ERR_CODE); end
    total++; if (bus.BUSY !== 1'b0)     begin bad++; $display("FAIL start_busy: got %b want 0", bus.BUSY); end
    for (int i = 0; i < 8; i++) send_bit(i[0]);
    total++; if (bus.ERR !== 1'b1 || bus.ERR_CODE !== 2'd1) begin bad++; $display("FAIL start_sticky: got err=%b code=%0d want err=1 code=1", bus.ERR, bus.ERR_CODE); end
    total++; if (we_n - base !== 2) begin bad++; $display("FAIL start_no_we_in_fail: got %0d want 2", we_n - base); end
  endtask

  task automatic test_bad_stop();
    int base;
    do_reset();
    base = we_n;
    send_stream(196, -1, 0, -1);
    repeat (4) tick();
    total++; if (bus.ERR_CODE !== 2'd2) begin bad++; $display("FAIL stop_code: got %0d want 2", bus.ERR_CODE); end
    total++; if (bus.ERR !== 1'b1)      begin bad++; $display("FAIL stop_err: got %b want 1", bus.ERR); end
    total++; if (we_n != base)          begin bad++; $display("FAIL stop_pulses: got %0d want 0", we_n - base); end
  endtask

  task automatic test_mid_reset();
    int base;
    do_reset();
    base = we_n;
    send_stream(196, -1, -1, 1);
    total++; if (bus.BUSY !== 1'b1) begin bad++; $display("FAIL midrst_busy_before: got %b want 1", bus.BUSY); end
    total++; if (we_n - base !== 1) begin bad++; $display("FAIL midrst_pulses_before: got %0d want 1", we_n - base); end
    do_reset();
    total++; if (bus.BUSY !== 1'b0)   begin bad++; $display("FAIL midrst_busy_after: got %b want 0", bus.BUSY); end
    total++; if (bus.CFG_WORD !== '0) begin bad++; $display("FAIL midrst_word_cleared: got %h want 0", bus.CFG_WORD); end
    base = we_n;
    send_stream(196, -1, -1, -1);
    repeat (4) tick();
    total++; if (we_n - base !== NC) begin bad++; $display("FAIL midrst_pulses: got %0d want %0d", we_n - base, NC); end
    for (int k = 0; k < NC; k++) begin
      total++; if (we_addr[base+k] !== k) begin bad++; $display("FAIL midrst_addr%0d: got %0d want %0d", k, we_addr[base+k], k); end
    end
    total++; if (bus.DONE !== 1'b1) begin bad++; $display("FAIL midrst_done: got %b want 1", bus.DONE); end
  endtask

  initial begin
    words[0]   = 38'h3_2345_6789;
    words[1]   = 38'h1_ABCD_EF01;
    words[2]   = 38'h2_5A5A_A5A5;
    words[3]   = 38'h0_F00F_0FF0;
    bus.DIN    = 1'b0;
    bus.DVALID = 1'b0;
    test_reset();
    test_nominal(1'b0);
    test_bad_length();
    test_bad_start();
    test_bad_stop();
    test_nominal(1'b1);
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/xc20xx_clb_cfg_loader.md
XC20XX_CLB_CFG_LOADER -- requirements
Module: xc20xx_clb_cfg_loader

Interface
REQ-001 Parameter NUM_CLB, default 64, number of CLBs (frames) loaded per bitstream.
REQ-002 Parameter CFG_BITS, default 38, configuration bits per CLB frame.
REQ-003 Port K  input  1  clock; one clock; all state updates on rising edge of K.
REQ-004 Port R  input  1  reset; synchronous, active-high.
REQ-005 Port DIN  input  1  serial bitstream data, MSB first.
REQ-006 Port DVALID  input  1  DIN accepted on an edge only when DVALID=1; DVALID=0 stalls the FSM with no state change.
REQ-007 Port CFG_WORD  output  CFG_BITS  parallel CLB configuration word; the field order from MSB down is F_INIT[7:0], G_INIT[7:0], F_IN0, F_IN1, F_IN2[1:0], G_IN0, G_IN1, G_IN2[1:0], MUX_FG, X_OUT[1:0], Y_OUT[1:0], S_IN[1:0], CLK_IN[1:0], CLK_POL[1:0], MODE, R_IN[1:0].
REQ-008 Port CFG_ADDR  output  clog2(NUM_CLB)  target CLB index of CFG_WORD.
REQ-009 Port CFG_WE  output  1  one-cycle write strobe for CFG_WORD/CFG_ADDR.
REQ-010 Port BUSY  output  1  high in LENGTH, FSTART, FDATA and FSTOP.
REQ-011 Ports DONE, ERR  output  1 each  sticky completion flag and sticky error flag.
REQ-012 Port ERR_CODE  output  2  error cause: 0 none, 1 bad start bit, 2 bad stop bit, 3 length mismatch.

Function
REQ-013 The FSM states SHALL be IDLE, LENGTH, FSTART, FDATA, FSTOP, WRITE, FIN and FAIL.
REQ-014 In IDLE, accepted bits SHALL shift into a 4-bit history register (reset value 4'b1111); when the history equals 4'b0010 after an accepted bit, the FSM SHALL go to LENGTH.
REQ-015 LENGTH SHALL accept 24 bits MSB first; on the 24th bit, if the value differs from 28 + NUM_CLB*(CFG_BITS+4), the FSM SHALL go to FAIL with code 3, otherwise to FSTART.
REQ-016 FSTART SHALL accept one bit; 0 goes to FDATA, 1 goes to FAIL with code 1.
REQ-017 FDATA SHALL accept exactly CFG_BITS bits into the frame shift register, then go to FSTOP.
REQ-018 FSTOP SHALL accept 3 bits; any 0 goes to FAIL with code 2 on that bit; after the third 1 the FSM SHALL go to WRITE.
REQ-019 WRITE SHALL last one cycle, independent of DVALID, and assert CFG_WE with CFG_WORD equal to the frame bits and CFG_ADDR equal to the frame index.
REQ-020 WRITE SHALL then go to FIN if the frame index equals NUM_CLB-1, otherwise increment the index and go to FSTART.
REQ-021 DIN presented during the WRITE cycle SHALL be ignored, and the source SHALL hold that bit for the next cycle.
REQ-022 FIN SHALL assert DONE; FAIL SHALL assert ERR and hold ERR_CODE; both SHALL remain until R, ignoring DIN/DVALID.
REQ-023 Frames already written before a failure SHALL NOT be retracted; CFG_WE SHALL never assert in FAIL or FIN.
REQ-024 CFG_WORD and CFG_ADDR SHALL hold their last written value between strobes.

Reset
REQ-025 R=1 SHALL, on the next edge, force IDLE, history 4'b1111, frame index 0, CFG_WORD 0, CFG_ADDR 0, CFG_WE 0, BUSY 0, DONE 0, ERR 0 and ERR_CODE 0.
REQ-026 R SHALL take priority over DVALID and over any state, including mid-frame and WRITE, in which case no strobe is issued.

Structure
REQ-027 A shared package SHALL hold the FSM state enum, the ERR_CODE constants, the CFG_WORD field offsets/widths and the expected-length function.
REQ-028 The frame deserializer (shift register plus bit counter) SHALL be a sub-module named xc20xx_cfg_frame_shift.

Verification
REQ-029 Nominal, NUM_CLB=4, CFG_BITS=38: 1111, 0010, length 196, 4 valid frames -> 4 CFG_WE pulses at ADDR 0..3 with the sent words; DONE=1; ERR=0.
REQ-030 Length 197 -> ERR=1, ERR_CODE=3, no CFG_WE.
REQ-031 Frame 2 start bit 1 -> exactly 2 CFG_WE pulses (ADDR 0,1); ERR_CODE=1; BUSY=0.
REQ-032 Frame 0 second stop bit 0 -> ERR_CODE=2, no CFG_WE.
REQ-033 Random DVALID gaps of 0-5 cycles -> CFG_WORD/ADDR sequence identical to REQ-029.
REQ-034 R asserted mid-FDATA of frame 1, then a full restream -> ADDR restarts at 0; final DONE=1.
